// File: rtl/apb_regfile_bridge.sv
// APB3 slave front-end for a small register file: turns APB transfers into one-cycle strobes.
// Optional: define APB_REGFILE_ADDR_ERR_EN to flag out-of-range addresses with pslverr.
module apb_regfile_bridge #(
    parameter int unsigned APB_AW = 8,
    parameter int unsigned RF_AW  = 4,
    parameter int unsigned RF_DW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [RF_AW-1:0]  rf_addr,
    output logic [RF_DW-1:0]  rf_wdata,
    input  logic [RF_DW-1:0]  rf_rdata
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_ISSUE = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_CAPT  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0] state;
    logic       addr_err;
    logic       unused_bits;

`ifdef APB_REGFILE_ADDR_ERR_EN
    assign addr_err = |paddr[APB_AW-1:RF_AW+2];
`else
    // Upper address bits are ignored, so high addresses alias onto the file.
    assign addr_err = 1'b0;
`endif

    // Byte-lane bits, upper address bits and upper write data are deliberately unused.
    assign unused_bits = ^{paddr, pwdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            rf_wr_en <= 1'b0;
            rf_rd_en <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && penable) begin
                        if (addr_err) begin
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                            if (!pwrite) begin
                                prdata <= '0;
                            end
                            state <= DONE;
                        end else begin
                            rf_addr <= paddr[RF_AW+1:2];
                            if (pwrite) begin
                                rf_wdata <= pwdata[RF_DW-1:0];
                                rf_wr_en <= 1'b1;
                                state    <= WR_ISSUE;
                            end else begin
                                rf_rd_en <= 1'b1;
                                state    <= RD_ISSUE;
                            end
                        end
                    end
                end
                WR_ISSUE: begin
                    rf_wr_en <= 1'b0;
                    pready   <= 1'b1;
                    state    <= DONE;
                end
                RD_ISSUE: begin
                    rf_rd_en <= 1'b0;
                    state    <= RD_CAPT;
                end
                RD_CAPT: begin
                    // Register file data is valid one cycle after the read strobe.
                    prdata <= 32'(rf_rdata);
                    pready <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// Directed bench for apb_regfile_bridge with a 16x8 register file model attached.
module tb_apb_regfile_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic [7:0]  rf_rdata;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         overlap = 0;
    logic [3:0] last_waddr;
    logic [7:0] last_wdata;
    logic [3:0] last_raddr;

    logic [7:0] mem [16];

    int          cyc;
    logic [31:0] rdat;
    logic        err;

    always #5 clk = ~clk;

    apb_regfile_bridge #(
        .APB_AW(8),
        .RF_AW (4),
        .RF_DW (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .rf_wr_en (rf_wr_en),
        .rf_rd_en (rf_rd_en),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    // Register file model: registered read, write sampled on the rising edge.
    always @(posedge clk) begin
        if (rf_wr_en) mem[rf_addr] <= rf_wdata;
        if (rf_rd_en) rf_rdata <= mem[rf_addr];
    end

    always @(negedge clk) begin
        if (rf_wr_en) begin
            wr_cnt++;
            last_waddr = rf_addr;
            last_wdata = rf_wdata;
        end
        if (rf_rd_en) begin
            rd_cnt++;
            last_raddr = rf_addr;
        end
        if (rf_wr_en && rf_rd_en) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns the access-cycle count at which pready was seen.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                       output int n, output logic [31:0] rd, output logic se);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        tick();
        penable = 1'b1;
        n = 1;
        while (pready !== 1'b1 && n <= 10) begin
            tick();
            n++;
        end
        rd = prdata;
        se = pslverr;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rf_rdata = 8'h00;
        reset   = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;

        // 1: reset
        tick();
        tick();
        reset = 1'b0;
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_wr_en", {31'b0, rf_wr_en}, 32'h0);
        check("rst_rd_en", {31'b0, rf_rd_en}, 32'h0);
        check("rst_addr", {28'b0, rf_addr}, 32'h0);
        check("rst_wdata", {24'b0, rf_wdata}, 32'h0);
        check("rst_state", {29'b0, dut.state}, 32'h0);
        wr_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) tick();
        check("idle_strobes", wr_cnt + rd_cnt, 32'd0);
        check("idle_pready", {31'b0, pready}, 32'h0);

        // 2: write entry 5
        apb(1'b1, 8'h14, 32'hDEADBEA5, cyc, rdat, err);
        check("wr_latency", cyc, 32'd3);
        check("wr_pslverr", {31'b0, err}, 32'h0);
        check("wr_pulses", wr_cnt, 32'd1);
        check("wr_no_read", rd_cnt, 32'd0);
        check("wr_addr", {28'b0, last_waddr}, 32'h5);
        check("wr_data", {24'b0, last_wdata}, 32'hA5);
        check("wr_pready_drop", {31'b0, pready}, 32'h0);

        // 3: read entry 5
        apb(1'b0, 8'h14, 32'h0, cyc, rdat, err);
        check("rd_latency", cyc, 32'd4);
        check("rd_data", rdat, 32'h000000A5);
        check("rd_pulses", rd_cnt, 32'd1);
        check("rd_addr", {28'b0, last_raddr}, 32'h5);
        check("rd_no_write", wr_cnt, 32'd1);

        // 4: back-to-back at minimum spacing
        wr_cnt = 0;
        rd_cnt = 0;
        overlap = 0;
        apb(1'b1, 8'h3C, 32'h0000003C, cyc, rdat, err);
        apb(1'b0, 8'h3C, 32'h0, cyc, rdat, err);
        check("b2b_rd_data", rdat, 32'h0000003C);
        apb(1'b1, 8'h00, 32'h0, cyc, rdat, err);
        check("b2b_wr_latency", cyc, 32'd3);
        tick();
        check("b2b_strobes", wr_cnt + rd_cnt, 32'd3);
        check("b2b_wr_cnt", wr_cnt, 32'd2);
        check("b2b_overlap", overlap, 32'd0);
        check("b2b_entry0", {24'b0, mem[0]}, 32'h0);

        // 5: reset during RD_ISSUE
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h3C;
        tick();
        penable = 1'b1;
        tick();
        check("mid_rd_issue", {31'b0, rf_rd_en}, 32'h1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        check("mid_state", {29'b0, dut.state}, 32'h0);
        check("mid_pready", {31'b0, pready}, 32'h0);
        check("mid_rd_en", {31'b0, rf_rd_en}, 32'h0);
        check("mid_prdata", prdata, 32'h0);
        tick();
        apb(1'b0, 8'h3C, 32'h0, cyc, rdat, err);
        check("post_rd_latency", cyc, 32'd4);
        check("post_rd_data", rdat, 32'h0000003C);

        // 6: out-of-range address
        wr_cnt = 0;
        apb(1'b1, 8'h40, 32'h00000077, cyc, rdat, err);
`ifdef APB_REGFILE_ADDR_ERR_EN
        check("oor_latency", cyc, 32'd2);
        check("oor_pslverr", {31'b0, err}, 32'h1);
        check("oor_no_write", wr_cnt, 32'd0);
        check("oor_pslverr_drop", {31'b0, pslverr}, 32'h0);
        apb(1'b0, 8'h00, 32'h0, cyc, rdat, err);
        check("oor_entry0", rdat, 32'h0);
`else
        check("alias_latency", cyc, 32'd3);
        check("alias_pslverr", {31'b0, err}, 32'h0);
        check("alias_write", wr_cnt, 32'd1);
        check("alias_addr", {28'b0, last_waddr}, 32'h0);
        apb(1'b0, 8'h00, 32'h0, cyc, rdat, err);
        check("alias_entry0", rdat, 32'h00000077);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_regfile_bridge.md
Name: apb_regfile_bridge

Overview:
APB3 slave front-end that sits directly upstream of the 16x8 register file on the fabric APB bus from the MSS. It converts single APB read/write transfers into the register file's one-cycle wr_en/rd_en strobes and captures the file's registered read data. It holds off the master with PREADY until the register file access has completed.

Parameters:
APB_AW, 8, APB address width (byte address).
RF_AW, 4, register file address width (16 entries).
RF_DW, 8, register file data width; must be 32 or less.

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  APB_AW  APB byte address
pwdata  input  32  APB write data
prdata  output  32  APB read data
pready  output  1  transfer complete
pslverr  output  1  transfer error
rf_wr_en  output  1  register file write strobe
rf_rd_en  output  1  register file read strobe
rf_addr  output  RF_AW  register file entry index
rf_wdata  output  RF_DW  register file write data
rf_rdata  input  RF_DW  register file data_out; valid the cycle after rf_rd_en

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered. While reset is high at a rising edge, the following are forced on that edge: state=IDLE, prdata=0, pready=0, pslverr=0, rf_wr_en=0, rf_rd_en=0, rf_addr=0, rf_wdata=0.
- Address map:
  - Word-aligned: rf_addr = paddr[RF_AW+1:2]; paddr[1:0] is ignored.
  - Writes use only pwdata[RF_DW-1:0]; the upper bits are discarded.
  - Reads return prdata = {zero-extend, rf_rdata}.
- States: IDLE, WR_ISSUE, RD_ISSUE, RD_CAPT, DONE.
- IDLE:
  - The setup phase (psel=1, penable=0) is ignored.
  - On the access phase (psel=1, penable=1) at edge E0, the bridge latches rf_addr and rf_wdata (writes only).
  - Write: rf_wr_en<=1, go to WR_ISSUE.
  - Read: rf_rd_en<=1, go to RD_ISSUE.
- WR_ISSUE: rf_wr_en=1 for exactly one cycle. Next edge: rf_wr_en<=0, pready<=1, go to DONE.
- RD_ISSUE: rf_rd_en=1 for exactly one cycle. Next edge: rf_rd_en<=0, go to RD_CAPT.
- RD_CAPT: rf_rdata is now valid. Next edge: prdata<=rf_rdata zero-extended, pready<=1, go to DONE.
- DONE: pready=1 for exactly one cycle. Next edge: pready<=0, pslverr<=0, go to IDLE. prdata holds its value until the next read capture.
- Latency, counted as access-phase cycles including the completing one: write = 3 (2 wait states); read = 4 (3 wait states).
- Strobes: rf_wr_en and rf_rd_en are never high together, and each pulses at most once per APB transfer.
- Back-to-back transfers: no transfer is accepted in the cycle pready=1. The next transfer is recognised from IDLE, which APB guarantees because the next access is preceded by a setup phase.
- psel or penable dropped mid-transfer (protocol violation): the internal sequence still completes, pready still pulses once, and the FSM returns to IDLE.
- Reset asserted mid-transfer: the FSM returns to IDLE at that edge and any pending strobe is cleared at that edge.
  - If reset lands on the edge that would have set rf_wr_en, no write occurs.
  - If rf_wr_en is already high during the reset cycle, the register file still samples it on that edge.

Optional Feature:
Macro APB_REGFILE_ADDR_ERR_EN.
- Defined:
  - Any access with paddr[APB_AW-1:RF_AW+2] != 0 is out of range. It issues no rf strobe, goes IDLE->DONE directly (1 wait state), with pready<=1, pslverr<=1, and prdata<=0 for reads.
  - pslverr=1 only in that DONE cycle.
- Not defined: pslverr is held 0, the upper address bits are ignored, and out-of-range addresses alias onto entries 0-15.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0, state IDLE, no strobe during the following 5 idle cycles.
2. APB write paddr=0x14, pwdata=0xDEADBEA5 -> rf_wr_en single pulse with rf_addr=5, rf_wdata=0xA5; pready high on the 3rd access cycle; pslverr=0.
3. APB read paddr=0x14 after test 2 (register file model attached) -> rf_rd_en single pulse with rf_addr=5; pready on the 4th access cycle with prdata=0x000000A5.
4. Back-to-back: write 0x3C->entry 15, read entry 15, write 0x00->entry 0 with minimum APB spacing -> read returns 0x0000003C, exactly 3 strobes total, never two strobes high together.
5. Reset asserted in the RD_ISSUE cycle of a read -> next cycle state IDLE, pready=0, rf_rd_en=0, prdata=0; a subsequent read of entry 15 completes normally.
6. paddr=0x40 write of 0x77: with APB_REGFILE_ADDR_ERR_EN -> no rf_wr_en, pready and pslverr=1 on the 2nd access cycle; without it -> entry 0 written with 0x77, pslverr=0.
